// File: rtl/stream_playback_if.sv
// AXI4 read-address/read-data channels and the 512-bit AXI-Stream output of stream_playback.
// master = playback engine side, slave = interconnect / stream sink side.
interface stream_playback_if;
    logic         axi_arready;
    logic [5:0]   axi_arid;
    logic [31:0]  axi_araddr;
    logic [7:0]   axi_arlen;
    logic [2:0]   axi_arsize;
    logic [1:0]   axi_arburst;
    logic         axi_arlock;
    logic [3:0]   axi_arcache;
    logic [2:0]   axi_arprot;
    logic         axi_arvalid;
    logic [511:0] axi_rd_data;
    logic [1:0]   axi_rd_resp;
    logic         axi_rd_last;
    logic         axi_rd_valid;
    logic         axi_rd_ready;
    logic         m_axis_tvalid;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic         m_axis_tready;

    modport master (
        input  axi_arready,
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
        output axi_arlock, axi_arcache, axi_arprot, axi_arvalid,
        input  axi_rd_data, axi_rd_resp, axi_rd_last, axi_rd_valid,
        output axi_rd_ready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        output axi_arready,
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
        input  axi_arlock, axi_arcache, axi_arprot, axi_arvalid,
        output axi_rd_data, axi_rd_resp, axi_rd_last, axi_rd_valid,
        input  axi_rd_ready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/stream_playback.sv
// DDR-to-stream playback: credit-limited AXI4 read bursts into a beat FIFO, replayed on AXI-Stream.
// Optional macro PLAYBACK_LOOP_EN: replay the region continuously while startPlayback stays high.
module stream_playback #(
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter logic [5:0]  AXI_ID     = 6'd0
) (
    input  logic               m_axi_aclk,
    input  logic               resetn_stream,
    input  logic               startPlayback,
    input  logic [31:0]        start_addr,
    input  logic [31:0]        playbackSize,
    stream_playback_if.master  bus,
    output logic               o_playback_start,
    output logic               o_done,
    output logic               o_error
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam logic [31:0] BL    = 32'(BURST_LEN);
    localparam logic [31:0] DEPTH = 32'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ABORT, S_DONE} state_t;
    state_t state, state_nx;

    logic          start_d;
    logic          start_pulse;
    logic [31:0]   base_addr;
    logic [31:0]   size_q;
    logic [31:0]   ar_addr;
    logic [31:0]   req_remaining;
    logic [31:0]   outstanding;
    logic [31:0]   sent_count;
    logic [31:0]   to_boundary;
    logic [31:0]   burst_len;
    logic [31:0]   credit;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_count;
    logic [511:0]  mem [FIFO_DEPTH];
    logic          ar_fire;
    logic          r_fire;
    logic          s_fire;
    logic          fifo_wr;
    logic          tlast_match;
    logic          unused_bits;

    assign start_pulse = o_playback_start & ~start_d;

    // Beats left before the next BURST_LEN*64-byte boundary keep bursts inside one 4 KB page.
    assign to_boundary = BL - ({6'd0, ar_addr[31:6]} & (BL - 32'd1));

    always_comb begin
        burst_len = BL;
        if (req_remaining < burst_len) burst_len = req_remaining;
        if (to_boundary < burst_len)   burst_len = to_boundary;
    end

    assign credit      = DEPTH - 32'(fifo_count) - outstanding;
    assign tlast_match = (sent_count == size_q - 32'd1);

    assign ar_fire = bus.axi_arvalid & bus.axi_arready;
    assign r_fire  = bus.axi_rd_valid & bus.axi_rd_ready;
    assign s_fire  = bus.m_axis_tvalid & bus.m_axis_tready;
    assign fifo_wr = r_fire & (state == S_RUN);

    assign bus.axi_arid    = AXI_ID;
    assign bus.axi_araddr  = ar_addr;
    assign bus.axi_arlen   = (burst_len == '0) ? '0 : 8'(burst_len - 32'd1);
    assign bus.axi_arsize  = 3'd6;
    assign bus.axi_arburst = 2'd1;
    assign bus.axi_arlock  = 1'b0;
    assign bus.axi_arcache = '0;
    assign bus.axi_arprot  = '0;
    assign bus.m_axis_tkeep = '1;
    assign bus.m_axis_tdata = bus.m_axis_tvalid ? mem[rd_ptr] : '0;
    assign bus.m_axis_tlast = bus.m_axis_tvalid & tlast_match;

    assign unused_bits = &{1'b0, bus.axi_rd_last, bus.axi_rd_resp[0], start_addr[5:0], base_addr};

    always_ff @(posedge m_axi_aclk or negedge resetn_stream) begin
        if (!resetn_stream) state <= S_IDLE;
        else                state <= state_nx;
    end

    always_comb begin
        state_nx          = state;
        bus.axi_arvalid   = 1'b0;
        bus.axi_rd_ready  = 1'b0;
        bus.m_axis_tvalid = 1'b0;
        o_done            = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_pulse) state_nx = (playbackSize == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                bus.axi_arvalid   = (req_remaining != '0) && (credit >= burst_len);
                bus.axi_rd_ready  = 1'b1;
                bus.m_axis_tvalid = (fifo_count != '0);
`ifdef PLAYBACK_LOOP_EN
                if (!o_playback_start) state_nx = S_ABORT;
`else
                if ((fifo_count != '0) && bus.m_axis_tready && tlast_match) state_nx = S_DONE;
                else if (!o_playback_start)                                 state_nx = S_ABORT;
`endif
            end
            S_ABORT: begin
                bus.axi_rd_ready = 1'b1;
                if (outstanding == '0) state_nx = S_IDLE;
            end
            S_DONE: begin
`ifndef PLAYBACK_LOOP_EN
                o_done = 1'b1;
`endif
                if (!o_playback_start) state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge resetn_stream) begin
        if (!resetn_stream) begin
            o_playback_start <= 1'b0;
            start_d          <= 1'b0;
            base_addr        <= '0;
            size_q           <= '0;
            ar_addr          <= '0;
            req_remaining    <= '0;
            outstanding      <= '0;
            sent_count       <= '0;
            o_error          <= 1'b0;
        end else begin
            o_playback_start <= startPlayback;
            start_d          <= o_playback_start;
            if (state == S_IDLE) begin
                if (start_pulse) begin
                    base_addr     <= {start_addr[31:6], 6'd0};
                    ar_addr       <= {start_addr[31:6], 6'd0};
                    size_q        <= playbackSize;
                    req_remaining <= playbackSize;
                    outstanding   <= '0;
                    sent_count    <= '0;
                    o_error       <= 1'b0;
                end
            end else begin
                if (ar_fire) begin
                    ar_addr       <= ar_addr + (burst_len << 6);
                    req_remaining <= req_remaining - burst_len;
                end
`ifdef PLAYBACK_LOOP_EN
                // Next pass is requested as soon as every request of the current pass is out.
                else if ((state == S_RUN) && (req_remaining == '0)) begin
                    ar_addr       <= base_addr;
                    req_remaining <= size_q;
                end
`endif
                if (ar_fire && r_fire)  outstanding <= outstanding + burst_len - 32'd1;
                else if (ar_fire)       outstanding <= outstanding + burst_len;
                else if (r_fire)        outstanding <= outstanding - 32'd1;
                if (r_fire && bus.axi_rd_resp[1]) o_error <= 1'b1;
                if (s_fire) sent_count <= bus.m_axis_tlast ? '0 : sent_count + 32'd1;
            end
        end
    end

    always_ff @(posedge m_axi_aclk) begin
        if (fifo_wr) mem[wr_ptr] <= bus.axi_rd_data;
    end

    // Leaving RUN (abort or completion) flushes the buffer; ABORT drops beats instead of writing.
    always_ff @(posedge m_axi_aclk or negedge resetn_stream) begin
        if (!resetn_stream) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (state != S_RUN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
            if (s_fire)  rd_ptr <= rd_ptr + AW'(1);
            if (fifo_wr && !s_fire)      fifo_count <= fifo_count + (AW+1)'(1);
            else if (!fifo_wr && s_fire) fifo_count <= fifo_count - (AW+1)'(1);
        end
    end
endmodule

// File: tb/tb_stream_playback.sv
// Directed self-checking bench for stream_playback: AXI read slave model, stream sink and
// per-scenario checks of AR sequence, replayed data, tlast, credit bound, abort and reset.
`timescale 1ns/1ps
module tb_stream_playback;
    localparam int unsigned BURST = 16;
    localparam int unsigned DEPTH = 64;

    logic        m_axi_aclk = 1'b0;
    logic        resetn_stream;
    logic        startPlayback;
    logic [31:0] start_addr;
    logic [31:0] playbackSize;
    logic        o_playback_start;
    logic        o_done;
    logic        o_error;

    stream_playback_if bus();

    stream_playback #(.BURST_LEN(BURST), .FIFO_DEPTH(DEPTH), .AXI_ID(6'd0)) dut (
        .m_axi_aclk       (m_axi_aclk),
        .resetn_stream    (resetn_stream),
        .startPlayback    (startPlayback),
        .start_addr       (start_addr),
        .playbackSize     (playbackSize),
        .bus              (bus.master),
        .o_playback_start (o_playback_start),
        .o_done           (o_done),
        .o_error          (o_error)
    );

    always #5 m_axi_aclk = ~m_axi_aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int ar_limit = -1;
    int tready_mode = 0;
    int r_period = 1;
    int err_beat = -1;
    int r_idx = 0;

    logic [31:0]  ar_addr_log[$];
    logic [7:0]   ar_len_log[$];
    logic [31:0]  r_q[$];
    logic         r_last_q[$];
    logic [511:0] st_data[$];
    logic         st_last[$];
    logic         st_err[$];
    int           issued, streamed, max_inflight, stall_changes;
    logic         prev_stall;
    logic [511:0] prev_data;

    function automatic logic [511:0] pat(input logic [31:0] a);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = a | 32'(i);
        return d;
    endfunction

    task automatic clear_logs();
        ar_addr_log.delete(); ar_len_log.delete();
        r_q.delete(); r_last_q.delete();
        st_data.delete(); st_last.delete(); st_err.delete();
        issued = 0; streamed = 0; max_inflight = 0; stall_changes = 0;
        prev_stall = 1'b0; prev_data = '0; r_idx = 0;
        bus.axi_rd_valid = 1'b0;
    endtask

    // One clock: drive slave/sink inputs at the falling edge, log the handshakes of the next rising edge.
    task automatic tick();
        logic ar_hs, r_hs, s_hs;
        bus.axi_arready = (ar_limit < 0) || (ar_addr_log.size() < ar_limit);
        if (r_q.size() != 0 && (cyc % r_period) == 0) begin
            bus.axi_rd_valid = 1'b1;
            bus.axi_rd_data  = pat(r_q[0]);
            bus.axi_rd_last  = r_last_q[0];
            bus.axi_rd_resp  = (r_idx == err_beat) ? 2'b10 : 2'b00;
        end else begin
            bus.axi_rd_valid = 1'b0;
            bus.axi_rd_data  = '0;
            bus.axi_rd_last  = 1'b0;
            bus.axi_rd_resp  = 2'b00;
        end
        case (tready_mode)
            0:       bus.m_axis_tready = 1'b1;
            1:       bus.m_axis_tready = ((cyc % 4) == 0);
            default: bus.m_axis_tready = 1'b0;
        endcase
        #1;
        ar_hs = bus.axi_arvalid && bus.axi_arready;
        r_hs  = bus.axi_rd_valid && bus.axi_rd_ready;
        s_hs  = bus.m_axis_tvalid && bus.m_axis_tready;
        if (prev_stall && (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== prev_data)) stall_changes++;
        prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_data  = bus.m_axis_tdata;
        if (r_hs) begin
            void'(r_q.pop_front());
            void'(r_last_q.pop_front());
            r_idx++;
        end
        if (ar_hs) begin
            ar_addr_log.push_back(bus.axi_araddr);
            ar_len_log.push_back(bus.axi_arlen);
            for (int i = 0; i <= int'(bus.axi_arlen); i++) begin
                r_q.push_back(bus.axi_araddr + 32'(i) * 32'd64);
                r_last_q.push_back(i == int'(bus.axi_arlen));
            end
            issued += int'(bus.axi_arlen) + 1;
        end
        if (s_hs) begin
            st_data.push_back(bus.m_axis_tdata);
            st_last.push_back(bus.m_axis_tlast);
            st_err.push_back(o_error);
            streamed++;
        end
        if (issued - streamed > max_inflight) max_inflight = issued - streamed;
        @(negedge m_axi_aclk);
        cyc++;
    endtask

    task automatic start_play(input logic [31:0] addr, input logic [31:0] size);
        start_addr = addr;
        playbackSize = size;
        startPlayback = 1'b1;
        tick();
    endtask

    task automatic stop_play();
        startPlayback = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_until_done(input int budget, output bit timed_out);
        int n = 0;
        while (o_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        timed_out = (o_done !== 1'b1);
    endtask

    task automatic test_reset();
        checks++; if (bus.axi_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", bus.axi_arvalid); end
        checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", bus.m_axis_tvalid); end
        checks++; if (bus.axi_rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b want 0", bus.axi_rd_ready); end
        checks++; if ({o_done, o_error, o_playback_start} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {o_done, o_error, o_playback_start}); end
        checks++; if (bus.m_axis_tkeep !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL reset_tkeep: got %h want all ones", bus.m_axis_tkeep); end
        checks++; if ({bus.axi_arsize, bus.axi_arburst, bus.axi_arid} !== {3'd6, 2'd1, 6'd0}) begin errors++; $display("FAIL ar_constants: got %h want %h", {bus.axi_arsize, bus.axi_arburst, bus.axi_arid}, {3'd6, 2'd1, 6'd0}); end
        checks++; if ({bus.axi_araddr, bus.axi_arlen} !== 40'd0) begin errors++; $display("FAIL reset_ar_fields: got %h want 0", {bus.axi_araddr, bus.axi_arlen}); end
    endtask

    task automatic test_single_pass();
        bit to;
        logic [31:0] exp_addr [3] = '{32'h1000, 32'h1400, 32'h1800};
        logic [7:0]  exp_len  [3] = '{8'd15, 8'd15, 8'd7};
        clear_logs();
        tready_mode = 0; r_period = 1; ar_limit = -1;
        start_play(32'h1000, 32'd40);
        run_until_done(400, to);
        checks++; if (to) begin errors++; $display("FAIL single_done_timeout: o_done got %b want 1", o_done); end
        checks++; if (ar_addr_log.size() != 3) begin errors++; $display("FAIL single_ar_count: got %0d want 3", ar_addr_log.size()); end
        for (int i = 0; i < 3 && i < ar_addr_log.size(); i++) begin
            checks++;
            if (ar_addr_log[i] !== exp_addr[i] || ar_len_log[i] !== exp_len[i]) begin
                errors++; $display("FAIL single_ar%0d: got %h/len%0d want %h/len%0d", i, ar_addr_log[i], ar_len_log[i], exp_addr[i], exp_len[i]);
            end
        end
        checks++; if (streamed != 40) begin errors++; $display("FAIL single_beats: got %0d want 40", streamed); end
        for (int k = 0; k < 40 && k < st_data.size(); k++) begin
            checks++;
            if (st_data[k] !== pat(32'h1000 + 32'(k) * 32'd64) || st_last[k] !== (k == 39)) begin
                errors++; $display("FAIL single_beat%0d: got data %h last %b want data %h last %b", k, st_data[k][31:0], st_last[k], pat(32'h1000 + 32'(k) * 32'd64) >> 0 & 512'hFFFF_FFFF, (k == 39));
            end
        end
        tick(); tick(); tick();
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL single_done_hold: got %b want 1", o_done); end
        stop_play();
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL single_done_clear: got %b want 0", o_done); end
    endtask

    task automatic test_boundary();
        bit to;
        clear_logs();
        tready_mode = 0; r_period = 1; ar_limit = -1;
        start_play(32'h0000_1FC5, 32'd4);
        run_until_done(200, to);
        checks++; if (to) begin errors++; $display("FAIL boundary_done_timeout: o_done got %b want 1", o_done); end
        checks++;
        if (ar_addr_log.size() != 2) begin
            errors++; $display("FAIL boundary_ar_count: got %0d want 2", ar_addr_log.size());
        end else if (ar_addr_log[0] !== 32'h1FC0 || ar_len_log[0] !== 8'd0 || ar_addr_log[1] !== 32'h2000 || ar_len_log[1] !== 8'd2) begin
            errors++; $display("FAIL boundary_ars: got %h/%0d %h/%0d want 00001fc0/0 00002000/2", ar_addr_log[0], ar_len_log[0], ar_addr_log[1], ar_len_log[1]);
        end
        checks++; if (streamed != 4) begin errors++; $display("FAIL boundary_beats: got %0d want 4", streamed); end
        for (int k = 0; k < 4 && k < st_data.size(); k++) begin
            checks++;
            if (st_data[k] !== pat(32'h1FC0 + 32'(k) * 32'd64) || st_last[k] !== (k == 3)) begin
                errors++; $display("FAIL boundary_beat%0d: got word0 %h last %b want word0 %h last %b", k, st_data[k][31:0], st_last[k], 32'h1FC0 + 32'(k) * 32'd64, (k == 3));
            end
        end
        stop_play();
    endtask

    task automatic test_backpressure();
        bit to;
        int bad = 0;
        int bad_last = 0;
        clear_logs();
        tready_mode = 1; r_period = 1; ar_limit = -1;
        start_play(32'h0001_0000, 32'd200);
        run_until_done(3000, to);
        checks++; if (to) begin errors++; $display("FAIL bp_done_timeout: o_done got %b want 1", o_done); end
        checks++; if (streamed != 200) begin errors++; $display("FAIL bp_beats: got %0d want 200", streamed); end
        for (int k = 0; k < st_data.size(); k++) begin
            if (st_data[k] !== pat(32'h0001_0000 + 32'(k) * 32'd64)) bad++;
            if (st_last[k] !== (k == 199)) bad_last++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_data: got %0d wrong beats want 0", bad); end
        checks++; if (bad_last != 0) begin errors++; $display("FAIL bp_tlast: got %0d wrong tlast flags want 0", bad_last); end
        checks++; if (max_inflight > int'(DEPTH)) begin errors++; $display("FAIL bp_credit: got max in flight %0d want <= %0d", max_inflight, DEPTH); end
        checks++; if (stall_changes != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes while stalled want 0", stall_changes); end
        checks++;
        if (ar_addr_log.size() != 13) begin
            errors++; $display("FAIL bp_ar_count: got %0d want 13", ar_addr_log.size());
        end else if (ar_addr_log[12] !== 32'h0001_3000 || ar_len_log[12] !== 8'd7) begin
            errors++; $display("FAIL bp_last_ar: got %h/%0d want 00013000/7", ar_addr_log[12], ar_len_log[12]);
        end
        stop_play();
    endtask

    task automatic test_error_resp();
        bit to;
        clear_logs();
        tready_mode = 0; r_period = 1; ar_limit = -1; err_beat = 5;
        start_play(32'h0000_4000, 32'd10);
        run_until_done(200, to);
        err_beat = -1;
        checks++; if (to) begin errors++; $display("FAIL err_done_timeout: o_done got %b want 1", o_done); end
        checks++;
        if (streamed != 10) begin
            errors++; $display("FAIL err_beats: got %0d want 10", streamed);
        end else begin
            checks++; if (st_err[4] !== 1'b0) begin errors++; $display("FAIL err_before: o_error at beat4 got %b want 0", st_err[4]); end
            checks++; if (st_err[5] !== 1'b1 || st_err[9] !== 1'b1) begin errors++; $display("FAIL err_after: o_error at beat5/9 got %b%b want 11", st_err[5], st_err[9]); end
            checks++; if (st_data[5] !== pat(32'h4140)) begin errors++; $display("FAIL err_data_fwd: got word0 %h want 00004140", st_data[5][31:0]); end
            checks++; if (st_last[9] !== 1'b1 || st_last[8] !== 1'b0) begin errors++; $display("FAIL err_tlast: got last8/9 %b%b want 01", st_last[8], st_last[9]); end
        end
        checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", o_error); end
        stop_play();
    endtask

    task automatic test_abort();
        bit to;
        int n = 0;
        int av_seen = 0;
        int tv_seen = 0;
        int st_at_abort;
        clear_logs();
        tready_mode = 0; r_period = 4; ar_limit = 2;
        start_play(32'h0000_8000, 32'd100);
        while (streamed < 3 && n < 300) begin tick(); n++; end
        checks++; if (streamed < 3) begin errors++; $display("FAIL abort_setup_timeout: got %0d beats want 3", streamed); end
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL abort_error_cleared: got %b want 0", o_error); end
        startPlayback = 1'b0;
        tick(); tick();
        st_at_abort = streamed;
        ar_limit = -1;
        n = 0;
        while (bus.axi_rd_ready === 1'b1 && n < 500) begin
            if (bus.axi_arvalid === 1'b1) av_seen++;
            if (bus.m_axis_tvalid === 1'b1) tv_seen++;
            tick();
            n++;
        end
        checks++; if (bus.axi_rd_ready !== 1'b0) begin errors++; $display("FAIL abort_drain_timeout: rd_ready got %b want 0", bus.axi_rd_ready); end
        checks++; if (ar_addr_log.size() != 2 || av_seen != 0) begin errors++; $display("FAIL abort_no_ar: got %0d ARs, %0d arvalid cycles want 2, 0", ar_addr_log.size(), av_seen); end
        checks++; if (tv_seen != 0 || streamed != st_at_abort) begin errors++; $display("FAIL abort_no_stream: got %0d tvalid cycles, %0d extra beats want 0, 0", tv_seen, streamed - st_at_abort); end
        checks++; if (r_q.size() != 0) begin errors++; $display("FAIL abort_drained: got %0d beats left want 0", r_q.size()); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", o_done); end
        clear_logs();
        r_period = 1;
        start_play(32'h0, 32'd2);
        run_until_done(100, to);
        checks++; if (to || streamed != 2) begin errors++; $display("FAIL abort_restart: got done %b beats %0d want 1, 2", o_done, streamed); end
        checks++; if (streamed == 2 && (st_data[1] !== pat(32'h40) || st_last[1] !== 1'b1)) begin errors++; $display("FAIL abort_restart_data: got word0 %h last %b want 00000040 1", st_data[1][31:0], st_last[1]); end
        stop_play();
    endtask

    task automatic test_size_zero();
        clear_logs();
        tready_mode = 0; r_period = 1; ar_limit = -1;
        start_play(32'h0000_3000, 32'd0);
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL zero_done_early: got %b want 0", o_done); end
        tick();
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", o_done); end
        tick(); tick();
        checks++; if (ar_addr_log.size() != 0 || bus.axi_arvalid !== 1'b0) begin errors++; $display("FAIL zero_no_ar: got %0d ARs arvalid %b want 0, 0", ar_addr_log.size(), bus.axi_arvalid); end
        stop_play();
    endtask

    task automatic test_reset_mid_run();
        clear_logs();
        tready_mode = 2; r_period = 1; ar_limit = 1;
        start_play(32'h0002_0000, 32'd100);
        for (int i = 0; i < 30; i++) tick();
        checks++; if (bus.axi_arvalid !== 1'b1 || bus.m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL midrun_setup: got arvalid %b tvalid %b want 1 1", bus.axi_arvalid, bus.m_axis_tvalid); end
        #2;
        resetn_stream = 1'b0;
        #1;
        checks++;
        if (bus.axi_arvalid !== 1'b0 || bus.m_axis_tvalid !== 1'b0 || o_done !== 1'b0) begin
            errors++; $display("FAIL async_reset: got arvalid %b tvalid %b done %b want 0 0 0", bus.axi_arvalid, bus.m_axis_tvalid, o_done);
        end
        startPlayback = 1'b0;
        ar_limit = -1;
        clear_logs();
        @(negedge m_axi_aclk);
        resetn_stream = 1'b1;
        tick(); tick();
        checks++; if (o_playback_start !== 1'b0 || bus.axi_rd_ready !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got start %b rd_ready %b want 0 0", o_playback_start, bus.axi_rd_ready); end
    endtask

    initial begin
        resetn_stream = 1'b0;
        startPlayback = 1'b0;
        start_addr = '0;
        playbackSize = '0;
        bus.axi_arready = 1'b0;
        bus.axi_rd_valid = 1'b0;
        bus.axi_rd_data = '0;
        bus.axi_rd_resp = '0;
        bus.axi_rd_last = 1'b0;
        bus.m_axis_tready = 1'b0;
        clear_logs();
        repeat (3) @(negedge m_axi_aclk);
        resetn_stream = 1'b1;
        @(negedge m_axi_aclk);
        test_reset();
        test_single_pass();
        test_boundary();
        test_backpressure();
        test_error_resp();
        test_abort();
        test_size_zero();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
